icache_fill: RTL and testbench
==============================

ICACHE_FILL -- requirements
Module: icache_fill

Interface
REQ-001 Parameter WORD_SIZE, 32, instruction/memory word width in bits.
REQ-002 Parameter BLOCK_SIZE, 1024, cache line width in bits (32 words, 128 bytes).
REQ-003 Parameter NUM_LINES, 8, direct-mapped line count (power of two).
REQ-004 clk  input  1  single clock; all state changes on posedge clk.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req_valid  input  1  fetch presents a line request this cycle.
REQ-007 req_addr  input  32  byte address from fetch; bits [6:0] ignored.
REQ-008 req_ready  output  1  cache can accept a request (state IDLE or RESP).
REQ-009 hit  output  1  line_out holds the line for the last accepted request.
REQ-010 line_out  output  BLOCK_SIZE  requested line; word at lowest address in bits [1023:992].
REQ-011 mem_req  output  1  refill beat request to instruction memory.
REQ-012 mem_addr  output  32  byte address of requested beat, word-aligned.
REQ-013 mem_valid  input  1  mem_rdata carries the beat for current mem_addr.
REQ-014 mem_rdata  input  WORD_SIZE  refill data word.

Function
REQ-015 Address split: index = req_addr[9:7], tag = req_addr[31:10]; tag and valid bit stored per line.
REQ-016 States: IDLE, REFILL, RESP; encoding free, no other reachable states.
REQ-017 IDLE/RESP, req_valid=1, valid[index] and tag match: next cycle state RESP, hit=1, line_out=stored line (1-cycle hit latency).
REQ-018 IDLE/RESP, req_valid=1, miss: next cycle state REFILL, hit=0, beat counter=0, latched line base = {req_addr[31:7],7'b0}.
REQ-019 IDLE/RESP, req_valid=0: state and hit unchanged; line_out holds last value.
REQ-020 REFILL: mem_req=1, mem_addr = line base + 4*beat, beat 0..31; req_ready=0; req_valid ignored.
REQ-021 REFILL, mem_valid=1: word beat written to line bits [1023-32*beat -: 32], beat increments; mem_valid=0 stalls with no change, unbounded wait allowed.
REQ-022 Beat 31 accepted: same edge sets valid[index], writes tag, state RESP, hit=1, line_out = completed line, mem_req=0 next cycle.
REQ-023 valid[index] stays 0 throughout refill; a partially filled line never produces hit.
REQ-024 mem_valid while mem_req=0 is ignored.
REQ-025 A miss evicts the resident line of that index unconditionally (no write-back; read-only cache).
REQ-026 Back-to-back requests in RESP accepted every cycle; hit drops to 0 the cycle after a missing request.
REQ-027 hit, req_ready, mem_req never X/Z after reset deassertion.

Reset
REQ-028 rst=1 at any time, including mid-refill: state IDLE, all valid bits 0, beat 0, hit 0, mem_req 0, mem_addr 0, line_out 0, req_ready 1; in-flight refill discarded.
REQ-029 Tag/data arrays need no reset; first post-reset request always misses.

Verification
REQ-030 Cold miss: reset, req_addr=0x0 -> 32 beats mem_addr 0x00..0x7C; mem_rdata=0x80000000+n -> hit=1, line_out[1023:992]=0x80000000, [31:0]=0x8000001F.
REQ-031 Re-hit: after REQ-030, req_addr=0x04 -> next cycle hit=1, mem_req=0, same line.
REQ-032 Conflict: req_addr=0x400 (index 0, tag 1) -> refill from 0x400; then 0x0 misses again.
REQ-033 Stall: mem_valid low 5 cycles at beat 10 -> mem_addr holds base+0x28, hit stays 0, data correct after completion.
REQ-034 Reset at beat 17 -> outputs per REQ-028 next edge; re-request same address performs full 32-beat refill.
REQ-035 req_valid toggled during REFILL with other addresses -> ignored; mem_addr sequence unchanged.

Source files
------------

// File: rtl/icache_fill_if.sv
// Fetch-side request/response and instruction-memory refill signals of icache_fill.
// "slave" is the cache side; "master" is the fetch unit / memory environment.
interface icache_fill_if #(
    parameter int WORD_SIZE  = 32,
    parameter int BLOCK_SIZE = 1024
) ();
    logic                  req_valid;
    logic [31:0]           req_addr;
    logic                  req_ready;
    logic                  hit;
    logic [BLOCK_SIZE-1:0] line_out;
    logic                  mem_req;
    logic [31:0]           mem_addr;
    logic                  mem_valid;
    logic [WORD_SIZE-1:0]  mem_rdata;

    modport master (
        output req_valid, req_addr, mem_valid, mem_rdata,
        input  req_ready, hit, line_out, mem_req, mem_addr
    );

    modport slave (
        input  req_valid, req_addr, mem_valid, mem_rdata,
        output req_ready, hit, line_out, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_fill.sv
// Direct-mapped, read-only instruction cache with a one-word-per-beat line refill
// engine. Hits answer in one cycle; misses stream a whole line from memory.
module icache_fill #(
    parameter int WORD_SIZE  = 32,
    parameter int BLOCK_SIZE = 1024,
    parameter int NUM_LINES  = 8
) (
    input  logic        clk,
    input  logic        rst,
    icache_fill_if.slave bus
);
    localparam int BEATS  = BLOCK_SIZE / WORD_SIZE;
    localparam int BEAT_W = $clog2(BEATS);
    localparam int OFF_W  = $clog2(BLOCK_SIZE / 8);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int LA_W   = 32 - OFF_W;
    localparam int TAG_W  = LA_W - IDX_W;
    localparam int WB_W   = OFF_W - BEAT_W;

    // Word 0 (lowest address) lives in the most significant slot.
    typedef logic [BEATS-1:0][WORD_SIZE-1:0] line_t;
    typedef enum logic [1:0] {S_IDLE, S_REFILL, S_RESP} state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_W-1:0]    r_tags [NUM_LINES];
    line_t               r_data [NUM_LINES];
    line_t               r_fill;
    line_t               r_line_out;
    logic                r_hit;
    logic [BEAT_W-1:0]   r_beat;
    logic [LA_W-1:0]     r_line_addr;

    logic [IDX_W-1:0]    w_req_idx;
    logic [TAG_W-1:0]    w_req_tag;
    logic [IDX_W-1:0]    w_fill_idx;
    logic [TAG_W-1:0]    w_fill_tag;
    logic                w_lookup_hit;
    logic                w_accepting;
    logic                w_beat_taken;
    logic                w_last_beat;
    logic [BEAT_W-1:0]   w_fill_slot;
    line_t               w_done_line;
    logic                w_unused_addr_bits;

    assign w_req_idx    = bus.req_addr[OFF_W +: IDX_W];
    assign w_req_tag    = bus.req_addr[31 -: TAG_W];
    assign w_fill_idx   = r_line_addr[IDX_W-1:0];
    assign w_fill_tag   = r_line_addr[LA_W-1:IDX_W];
    assign w_lookup_hit = r_valid[w_req_idx] && (r_tags[w_req_idx] == w_req_tag);
    assign w_accepting  = (r_state != S_REFILL) && bus.req_valid;
    assign w_beat_taken = (r_state == S_REFILL) && bus.mem_valid;
    assign w_last_beat  = (r_beat == BEAT_W'(BEATS - 1));
    assign w_fill_slot  = BEAT_W'(BEATS - 1) - r_beat;
    assign w_unused_addr_bits = ^bus.req_addr[OFF_W-1:0];

    // The final beat is merged on the fly so the line is usable on the same edge.
    always_comb begin
        w_done_line    = r_fill;
        w_done_line[0] = bus.mem_rdata;
    end

    assign bus.req_ready = (r_state != S_REFILL);
    assign bus.mem_req   = (r_state == S_REFILL);
    assign bus.mem_addr  = {r_line_addr, r_beat, {WB_W{1'b0}}};
    assign bus.hit       = r_hit;
    assign bus.line_out  = r_line_out;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: the default at the top of a combinational block keeps every path
    // assigned, so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_RESP: begin
                if (bus.req_valid) w_next_state = w_lookup_hit ? S_RESP : S_REFILL;
            end
            S_REFILL: begin
                if (bus.mem_valid && w_last_beat) w_next_state = S_RESP;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= '0;
            r_hit       <= 1'b0;
            r_beat      <= '0;
            r_line_addr <= '0;
            r_line_out  <= '0;
        end else if (w_accepting) begin
            if (w_lookup_hit) begin
                r_hit      <= 1'b1;
                r_line_out <= r_data[w_req_idx];
            end else begin
                // Evict immediately so a half-filled line can never look valid.
                r_hit              <= 1'b0;
                r_beat             <= '0;
                r_line_addr        <= bus.req_addr[31:OFF_W];
                r_valid[w_req_idx] <= 1'b0;
            end
        end else if (w_beat_taken) begin
            r_beat <= r_beat + 1'b1;
            if (w_last_beat) begin
                r_valid[w_fill_idx] <= 1'b1;
                r_hit               <= 1'b1;
                r_line_out          <= w_done_line;
            end
        end
    end

    // NOTE: tag/data storage and the fill buffer carry no reset; the valid
    // bits alone decide whether their contents are trusted.
    always_ff @(posedge clk) begin
        if (w_beat_taken) begin
            r_fill[w_fill_slot] <= bus.mem_rdata;
            if (w_last_beat) begin
                r_tags[w_fill_idx] <= w_fill_tag;
                r_data[w_fill_idx] <= w_done_line;
            end
        end
    end
endmodule

// File: tb/tb_icache_fill.sv
// Randomized self-checking bench for icache_fill against a line-level cache model.
module tb_icache_fill;
    logic clk = 1'b0;
    logic rst = 1'b1;

    icache_fill_if #(.WORD_SIZE(32), .BLOCK_SIZE(1024)) bus ();

    icache_fill #(.WORD_SIZE(32), .BLOCK_SIZE(1024), .NUM_LINES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: what each of the 8 lines is believed to hold.
    bit           m_valid [8];
    logic [21:0]  m_tag   [8];
    logic [1023:0] m_line [8];

    task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        int w;
        n_checks++;
        if (got !== exp) begin
            w = 0;
            for (int i = 0; i < 32; i++) begin
                if (got[i*32 +: 32] !== exp[i*32 +: 32]) begin
                    w = i;
                    break;
                end
            end
            n_errors++;
            $display("FAIL %s: got %h, expected %h (bits %0d+:32)",
                     tag, got[w*32 +: 32], exp[w*32 +: 32], w * 32);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hit"},   1024'(bus.hit), 1024'(0));
        check({tag, "_mreq"},  1024'(bus.mem_req), 1024'(0));
        check({tag, "_maddr"}, 1024'(bus.mem_addr), 1024'(0));
        check({tag, "_line"},  bus.line_out, 1024'(0));
        check({tag, "_ready"}, 1024'(bus.req_ready), 1024'(1));
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    endtask

    // One fetch request; on a miss it plays memory for 32 beats.
    // seq_data: beat n returns 0x80000000+n; stall_beat/stall_len: memory pause;
    // abort_beat: assert reset just before that beat; noise: junk requests while refilling.
    task automatic do_request(input logic [31:0] addr, input bit seq_data,
                              input int stall_beat, input int stall_len,
                              input int abort_beat, input bit noise);
        logic [31:0]   base;
        logic [31:0]   w;
        logic [21:0]   tag;
        logic [1023:0] line;
        int            idx;
        bit            exp_hit;
        base    = {addr[31:7], 7'b0};
        idx     = int'(addr[9:7]);
        tag     = addr[31:10];
        exp_hit = m_valid[idx] && (m_tag[idx] == tag);
        line    = '0;

        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        tick();
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;

        if (exp_hit) begin
            check("hit_hit",   1024'(bus.hit), 1024'(1));
            check("hit_mreq",  1024'(bus.mem_req), 1024'(0));
            check("hit_ready", 1024'(bus.req_ready), 1024'(1));
            check("hit_line",  bus.line_out, m_line[idx]);
            return;
        end

        check("miss_hit",   1024'(bus.hit), 1024'(0));
        check("miss_mreq",  1024'(bus.mem_req), 1024'(1));
        check("miss_ready", 1024'(bus.req_ready), 1024'(0));
        m_valid[idx] = 1'b0;

        for (int n = 0; n < 32; n++) begin
            if (n == abort_beat) begin
                bus.mem_valid = 1'b0;
                rst = 1'b1;
                tick();
                check_reset_outputs("abort");
                rst = 1'b0;
                clear_model();
                return;
            end
            if (n == stall_beat) begin
                for (int s = 0; s < stall_len; s++) begin
                    bus.mem_valid = 1'b0;
                    bus.mem_rdata = $urandom;
                    if (noise) begin
                        bus.req_valid = 1'($urandom_range(0, 1));
                        bus.req_addr  = $urandom;
                    end
                    tick();
                    check("stall_addr", 1024'(bus.mem_addr), 1024'(base + 32'(4 * n)));
                    check("stall_hit",  1024'(bus.hit), 1024'(0));
                end
            end
            check("beat_addr", 1024'(bus.mem_addr), 1024'(base + 32'(4 * n)));
            w = seq_data ? 32'h8000_0000 + 32'(n) : $urandom;
            line[1023 - 32 * n -: 32] = w;
            bus.mem_valid = 1'b1;
            bus.mem_rdata = w;
            if (noise) begin
                bus.req_valid = 1'($urandom_range(0, 1));
                bus.req_addr  = $urandom;
            end
            tick();
        end
        bus.mem_valid = 1'b0;
        bus.req_valid = 1'b0;

        check("fill_hit",   1024'(bus.hit), 1024'(1));
        check("fill_mreq",  1024'(bus.mem_req), 1024'(0));
        check("fill_ready", 1024'(bus.req_ready), 1024'(1));
        check("fill_line",  bus.line_out, line);
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tag;
        m_line[idx]  = line;
    endtask

    // Idle cycles with stray memory beats; the held response must not move.
    task automatic idle_hold(input int cycles, input bit exp_hit, input logic [1023:0] exp_line);
        for (int i = 0; i < cycles; i++) begin
            bus.req_valid = 1'b0;
            bus.mem_valid = 1'b1;
            bus.mem_rdata = $urandom;
            tick();
            check("idle_hit",  1024'(bus.hit), 1024'(exp_hit));
            check("idle_mreq", 1024'(bus.mem_req), 1024'(0));
            check("idle_line", bus.line_out, exp_line);
        end
        bus.mem_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.mem_valid = 1'b0;
        bus.mem_rdata = '0;
        clear_model();

        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();
        check_reset_outputs("post_reset");

        // Cold miss with a recognisable data pattern, then a same-line hit.
        do_request(32'h0000_0000, 1'b1, 99, 0, 99, 1'b0);
        check("cold_word0",  1024'(bus.line_out[1023:992]), 1024'(32'h8000_0000));
        check("cold_word31", 1024'(bus.line_out[31:0]), 1024'(32'h8000_001F));
        do_request(32'h0000_0004, 1'b0, 99, 0, 99, 1'b0);
        idle_hold(3, 1'b1, m_line[0]);

        // Conflict on index 0 evicts, so the original line misses again.
        do_request(32'h0000_0400, 1'b0, 99, 0, 99, 1'b0);
        do_request(32'h0000_0000, 1'b0, 99, 0, 99, 1'b0);

        // Five-cycle memory stall at beat 10 with junk requests throughout.
        do_request(32'h0000_1280, 1'b0, 10, 5, 99, 1'b1);
        do_request(32'h0000_12FC, 1'b0, 99, 0, 99, 1'b0);

        // Reset in the middle of a refill, then a full refill of the same line.
        do_request(32'h0000_2300, 1'b0, 99, 0, 17, 1'b0);
        tick();
        check_reset_outputs("after_abort");
        do_request(32'h0000_2300, 1'b0, 99, 0, 99, 1'b1);
        do_request(32'h0000_0000, 1'b0, 99, 0, 99, 1'b0);

        // Random traffic over a few tags per index to mix hits and conflicts.
        for (int k = 0; k < 60; k++) begin
            a = (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(0, 7)) << 7)
                | 32'($urandom_range(0, 127));
            do_request(a, 1'b0, $urandom_range(0, 40), $urandom_range(1, 4), 99,
                       1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle_hold($urandom_range(1, 3), bus.hit, bus.line_out);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no completion, expected finish before time limit");
        $fatal(1, "timeout");
    end
endmodule
